// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin front end for a single-port DEPTH x DATA_W memory.
// Every reset runs a clear pass that zeroes all words before any request is served.

module mem_rr_arbiter_rsp #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_fire,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   always_comb begin
      rvalid_d = rd_fire;
      rdata_d  = rd_fire ? mem_rdata : rdata_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

   // A reset arriving while a response is on the wire cancels it outright.
   assign rvalid = rvalid_q & rst_n;
   assign rdata  = rdata_q;

endmodule

module mem_rr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ready,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_valid,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ready,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic              init_done
);

   localparam int NUM_REQ = 2;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_SERVE = 1'b1;
   localparam logic [0:0] PTR_A    = 1'b0;
   localparam logic [0:0] PTR_B    = 1'b1;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   req_t [NUM_REQ-1:0]              req;
   logic [NUM_REQ-1:0]              grant;
   logic [NUM_REQ-1:0]              rd_fire;
   logic [NUM_REQ-1:0]              rvalid;
   logic [NUM_REQ-1:0][DATA_W-1:0]  rdata;

   logic [0:0]        state_q, state_d;
   logic [0:0]        ptr_q, ptr_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              init_done_q, init_done_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   always_comb begin
      req[0].valid = a_valid;
      req[0].we    = a_we;
      req[0].addr  = a_addr;
      req[0].wdata = a_wdata;
      req[1].valid = b_valid;
      req[1].we    = b_we;
      req[1].addr  = b_addr;
      req[1].wdata = b_wdata;
   end

   // Pointer only breaks ties; a lone requester is always granted.
   always_comb begin
      grant = '0;
      if (state_q == ST_SERVE) begin
         if (req[0].valid && (!req[1].valid || ptr_q == PTR_A)) grant[0] = 1'b1;
         else if (req[1].valid)                                 grant[1] = 1'b1;
      end
   end

   always_comb begin
      sel_we    = grant[1] ? req[1].we    : req[0].we;
      sel_addr  = grant[1] ? req[1].addr  : req[0].addr;
      sel_wdata = grant[1] ? req[1].wdata : req[0].wdata;
      rd_fire   = grant & {NUM_REQ{~sel_we}};
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
      if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_addr  = clr_cnt_q;
         mem_wdata = '0;
      end else if (|grant && sel_we) begin
         mem_we = 1'b1;
      end
   end

   assign mem_rdata = mem_q[mem_addr];

   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_wdata;
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      clr_cnt_d   = clr_cnt_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
               state_d     = ST_SERVE;
               init_done_d = 1'b1;
            end
         end
         default: begin
            if (grant[0])      ptr_d = PTR_B;
            else if (grant[1]) ptr_d = PTR_A;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_CLEAR;
         ptr_q       <= PTR_A;
         clr_cnt_q   <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         clr_cnt_q   <= clr_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_rsp
      mem_rr_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_fire   (rd_fire[g]),
         .mem_rdata (mem_rdata),
         .rvalid    (rvalid[g]),
         .rdata     (rdata[g])
      );
   end

   assign a_ready   = grant[0];
   assign b_ready   = grant[1];
   assign a_rvalid  = rvalid[0];
   assign b_rvalid  = rvalid[1];
   assign a_rdata   = rdata[0];
   assign b_rdata   = rdata[1];
   assign init_done = init_done_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Scoreboard bench for mem_rr_arbiter: a reference model predicts grants, init_done and
// read data; expected reads are queued at grant time and retired on rvalid.
module tb_mem_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       a_valid, a_we, b_valid, b_we;
   logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
   logic       a_ready, a_rvalid, b_ready, b_rvalid, init_done;
   logic [7:0] a_rdata, b_rdata;

   typedef struct {
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } op_t;

   op_t        aq[$], bq[$];
   logic [7:0] qa[$], qb[$];
   bit         glog[$];
   logic [7:0] m_mem [256];
   bit         m_known = 0, m_serve = 0, m_ptr = 0;
   bit         pend_a = 0, pend_b = 0, ga_seen = 0, gb_seen = 0;
   int         m_cnt = 0;
   int         vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   mem_rr_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .init_done(init_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: checks the current cycle, then advances to the state after the next edge.
   always @(negedge clk) begin
      bit ga, gb;
      ga = m_serve && a_valid && (!b_valid || !m_ptr);
      gb = m_serve && b_valid && !ga;
      if (m_known) begin
         chk("init_done", init_done, m_serve);
         chk("a_ready", a_ready, ga);
         chk("b_ready", b_ready, gb);
         chk("a_rvalid", a_rvalid, pend_a && rst_n);
         chk("b_rvalid", b_rvalid, pend_b && rst_n);
         if (pend_a && rst_n) begin
            chk("a_sb_depth", qa.size(), 1);
            if (qa.size() > 0) chk("a_rdata", a_rdata, qa.pop_front());
         end
         if (pend_b && rst_n) begin
            chk("b_sb_depth", qb.size(), 1);
            if (qb.size() > 0) chk("b_rdata", b_rdata, qb.pop_front());
         end
      end
      ga_seen = rst_n && ga;
      gb_seen = rst_n && gb;
      if (!rst_n) begin
         m_known = 1; m_serve = 0; m_cnt = 0; m_ptr = 0;
         pend_a = 0; pend_b = 0;
         qa.delete(); qb.delete();
         foreach (m_mem[i]) m_mem[i] = 8'h00;
      end else if (m_known) begin
         pend_a = 0; pend_b = 0;
         if (!m_serve) begin
            if (m_cnt == 255) m_serve = 1;
            m_cnt++;
         end else begin
            if (ga) begin
               glog.push_back(1'b0);
               if (a_we) m_mem[a_addr] = a_wdata;
               else begin qa.push_back(m_mem[a_addr]); pend_a = 1; end
               m_ptr = 1;
            end
            if (gb) begin
               glog.push_back(1'b1);
               if (b_we) m_mem[b_addr] = b_wdata;
               else begin qb.push_back(m_mem[b_addr]); pend_b = 1; end
               m_ptr = 0;
            end
         end
      end
   end

   // Requesters: present the queue head, hold it until granted.
   always @(posedge clk) begin
      #1;
      if (ga_seen && aq.size() > 0) aq.delete(0);
      if (gb_seen && bq.size() > 0) bq.delete(0);
      if (aq.size() > 0) begin
         a_valid = 1; a_we = aq[0].we; a_addr = aq[0].addr; a_wdata = aq[0].wdata;
      end else a_valid = 0;
      if (bq.size() > 0) begin
         b_valid = 1; b_we = bq[0].we; b_addr = bq[0].addr; b_wdata = bq[0].wdata;
      end else b_valid = 0;
   end

   task automatic push_a(input bit we, input logic [7:0] addr, input logic [7:0] wd);
      op_t o; o.we = we; o.addr = addr; o.wdata = wd; aq.push_back(o);
   endtask

   task automatic push_b(input bit we, input logic [7:0] addr, input logic [7:0] wd);
      op_t o; o.we = we; o.addr = addr; o.wdata = wd; bq.push_back(o);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((aq.size() > 0 || bq.size() > 0 || pend_a || pend_b) && n < 600) begin
         @(negedge clk); n++;
      end
      chk({tag, "_timeout"}, n < 600, 1);
      repeat (2) @(negedge clk);
      #1;
   endtask

   task automatic wait_init(input string tag);
      int n = 0;
      while (!init_done && n < 400) begin @(negedge clk); n++; end
      chk({tag, "_timeout"}, n < 400, 1);
      #1;
   endtask

   task automatic do_reset(input int ncyc);
      @(posedge clk); #1; rst_n = 0;
      repeat (ncyc) @(posedge clk);
      #1; rst_n = 1;
   endtask

   function automatic logic [5:0] glog_bits(input int n);
      logic [5:0] v = '0;
      for (int i = 0; i < n && i < glog.size(); i++) v = {v[4:0], glog[i]};
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, miscompares %0d", miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
      b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1;
      @(negedge clk); #1;
      chk("rst_init_done", init_done, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_a_rdata", a_rdata, 0);
      chk("rst_b_rdata", b_rdata, 0);
      wait_init("init0");

      // post-clear reads
      push_a(0, 8'h00, 8'h00); push_a(0, 8'h05, 8'h00); push_b(0, 8'hFF, 8'h00);
      wait_idle("clear_reads");

      push_a(1, 8'h05, 8'h00); push_a(0, 8'h05, 8'h00);
      push_a(1, 8'h05, 8'h05); push_a(0, 8'h05, 8'h00);
      wait_idle("a_wr_rd");
      chk("a_rdata_hold", a_rdata, 8'h05);

      push_b(0, 8'h05, 8'h00);
      wait_idle("b_rd");
      chk("b_rdata_hold", b_rdata, 8'h05);

      // contention: pointer now names A
      glog.delete();
      for (int i = 0; i < 3; i++) begin
         push_a(0, 8'h10, 8'h00);
         push_b(1, 8'h10, 8'hAA + 8'(i));
      end
      wait_idle("contend");
      chk("grant_count", glog.size(), 6);
      chk("grant_order", glog_bits(6), 6'b010101);
      chk("contend_a_rdata", a_rdata, 8'hAB);

      // requests raised mid-clear wait for init_done, A first
      do_reset(2);
      repeat (100) @(negedge clk);
      #1;
      glog.delete();
      push_a(0, 8'h10, 8'h00); push_b(0, 8'h05, 8'h00);
      wait_idle("clear_req");
      chk("clear_req_count", glog.size(), 2);
      chk("clear_first_grant", glog_bits(1), 0);

      push_a(1, 8'h20, 8'h5A); push_a(0, 8'h20, 8'h00);
      wait_idle("wr_5a");
      chk("rd_5a", a_rdata, 8'h5A);
      repeat (20) @(negedge clk);
      do_reset(1);
      wait_init("init_reclear");
      @(negedge clk); #1;
      push_a(0, 8'h20, 8'h00); push_b(0, 8'h00, 8'h00);
      wait_idle("reclear_rd");
      chk("reclear_a_rdata", a_rdata, 8'h00);

      // read granted, then reset in the following cycle
      push_a(0, 8'h20, 8'h00);
      @(posedge clk); #1;
      @(posedge clk); #1; rst_n = 0;
      @(negedge clk); #1;
      chk("abort_rvalid_a", a_rvalid, 0);
      @(posedge clk); #1; rst_n = 1;
      @(negedge clk); #1;
      chk("abort_init_done", init_done, 0);
      chk("abort_rvalid_a2", a_rvalid, 0);
      wait_init("init_abort");
      repeat (3) @(negedge clk);
      #1;
      chk("sb_a_empty", qa.size(), 0);
      chk("sb_b_empty", qb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
